// File: rtl/uart_frame_builder.sv
// uart_frame_builder: parses 12-byte UART frames (sync, id, 8 data, xor checksum)
// and launches them to a CAN transmitter through a one-deep pending buffer.
module uart_frame_builder #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 10000,
  parameter int         GUARD_CYC   = 110
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] Can_ID_Bus,
  output logic [63:0] can_tx_data_bus,
  output logic        Frame_ready,
  output logic        Load_frame_datareg,
  output logic        T_frame,
  output logic        busy,
  output logic        frame_err,
  output logic        overrun
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(GUARD_CYC + 1);
  localparam logic [2:0] HUNT = 3'd0, ID_HI = 3'd1, ID_LO = 3'd2, DATA = 3'd3, CSUM = 3'd4;
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, FIRE = 2'd2, GUARD = 2'd3;
  logic [2:0]    ps_q, ps_d, idx_q, idx_d;
  logic [7:0]    x_q, x_d;
  logic [11:0]   sid_q, sid_d, pid_q, pid_d, id_q, id_d;
  logic [63:0]   sdat_q, sdat_d, pdat_q, pdat_d, dat_q, dat_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [1:0]    ls_q, ls_d;
  logic          pend_q, pend_d, err_q, err_d, ovr_q, ovr_d;
  logic          timeout, good, bad, launch, store;
  always_comb begin
    tmo_d   = rx_valid ? '0 : (tmo_q == TW'(TIMEOUT_CYC)) ? tmo_q : tmo_q + 1'b1;
    timeout = !rx_valid && ps_q != HUNT && tmo_q == TW'(TIMEOUT_CYC - 1);
    good    = rx_valid && ps_q == CSUM && rx_data == x_q;
    bad     = rx_valid && ps_q == CSUM && rx_data != x_q;
    ps_d    = ps_q;
    idx_d   = idx_q;
    x_d     = x_q;
    sid_d   = sid_q;
    sdat_d  = sdat_q;
    if (timeout) ps_d = HUNT;
    else if (rx_valid)
      case (ps_q)
        HUNT: begin
          ps_d = (rx_data == SYNC_BYTE) ? ID_HI : HUNT;
          x_d  = '0;
        end
        ID_HI: begin
          sid_d[11:8] = rx_data[3:0];
          x_d         = rx_data;
          ps_d        = ID_LO;
        end
        ID_LO: begin
          sid_d[7:0] = rx_data;
          x_d        = x_q ^ rx_data;
          idx_d      = '0;
          ps_d       = DATA;
        end
        DATA: begin
          sdat_d[{idx_q, 3'b000} +: 8] = rx_data;
          x_d   = x_q ^ rx_data;
          idx_d = idx_q + 1'b1;
          ps_d  = (idx_q == 3'd7) ? CSUM : DATA;
        end
        default: ps_d = HUNT;
      endcase
  end
  // A frame completing while idle launches straight from the shadow; one that
  // completes on the cycle the pending frame launches takes the freed slot.
  always_comb begin
    launch = ls_q == IDLE && (pend_q || good);
    store  = good && (pend_q ? launch : !launch);
    pend_d = store || (pend_q && !launch);
    pid_d  = store ? sid_q : pid_q;
    pdat_d = store ? sdat_q : pdat_q;
    id_d   = launch ? (pend_q ? pid_q : sid_q) : id_q;
    dat_d  = launch ? (pend_q ? pdat_q : sdat_q) : dat_q;
    err_d  = bad || timeout;
    ovr_d  = good && pend_q && !launch;
    gcnt_d = (ls_q == GUARD) ? gcnt_q + 1'b1 : '0;
    ls_d   = ls_q == IDLE ? (launch ? LOAD : IDLE) :
             ls_q == LOAD ? FIRE :
             ls_q == FIRE ? GUARD :
             (gcnt_q == GW'(GUARD_CYC - 1)) ? IDLE : GUARD;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ps_q   <= HUNT;
      idx_q  <= '0;
      x_q    <= '0;
      sid_q  <= '0;
      sdat_q <= '0;
      tmo_q  <= '0;
      pend_q <= 1'b0;
      pid_q  <= '0;
      pdat_q <= '0;
      id_q   <= '0;
      dat_q  <= '0;
      ls_q   <= IDLE;
      gcnt_q <= '0;
      err_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ps_q   <= ps_d;
      idx_q  <= idx_d;
      x_q    <= x_d;
      sid_q  <= sid_d;
      sdat_q <= sdat_d;
      tmo_q  <= tmo_d;
      pend_q <= pend_d;
      pid_q  <= pid_d;
      pdat_q <= pdat_d;
      id_q   <= id_d;
      dat_q  <= dat_d;
      ls_q   <= ls_d;
      gcnt_q <= gcnt_d;
      err_q  <= err_d;
      ovr_q  <= ovr_d;
    end
  end
  assign Can_ID_Bus         = id_q;
  assign can_tx_data_bus    = dat_q;
  assign Frame_ready        = ls_q == LOAD;
  assign Load_frame_datareg = ls_q == LOAD;
  assign T_frame            = ls_q == FIRE;
  assign busy               = ls_q != IDLE;
  assign frame_err          = err_q;
  assign overrun            = ovr_q;
endmodule

// File: tb/tb_uart_frame_builder.sv
// tb_uart_frame_builder: directed and randomized frames against an expected-launch
// queue, with a negedge monitor checking launch contents and pulse timing.
module tb_uart_frame_builder;
  localparam int GUARD = 110;
  logic        clock = 0, reset = 1, rx_valid = 0;
  logic [7:0]  rx_data = 0;
  logic [11:0] Can_ID_Bus;
  logic [63:0] can_tx_data_bus;
  logic        Frame_ready, Load_frame_datareg, T_frame, busy, frame_err, overrun;
  int checks = 0, errors = 0;
  int fr_cnt = 0, tf_cnt = 0, err_cnt = 0, ovr_cnt = 0, busy_run = 0;
  logic prev_fr = 0;
  logic [75:0] exp_q[$];

  uart_frame_builder dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .Can_ID_Bus(Can_ID_Bus), .can_tx_data_bus(can_tx_data_bus),
    .Frame_ready(Frame_ready), .Load_frame_datareg(Load_frame_datareg),
    .T_frame(T_frame), .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      prev_fr  = 0;
      busy_run = 0;
    end else begin
      if (Frame_ready) begin
        fr_cnt++;
        chk("load_strobe", Load_frame_datareg, 1);
        if (exp_q.size() == 0) chk("unexpected_launch", Frame_ready, 0);
        else begin
          logic [75:0] e;
          e = exp_q.pop_front();
          chk("launch_id", Can_ID_Bus, e[75:64]);
          chk("launch_data", can_tx_data_bus, e[63:0]);
        end
      end
      if (prev_fr || T_frame) chk("t_frame_follows_load", T_frame, prev_fr);
      if (T_frame) tf_cnt++;
      if (frame_err) err_cnt++;
      if (overrun) ovr_cnt++;
      if (busy) busy_run++;
      else if (busy_run > 0) begin
        chk("busy_length", busy_run, GUARD + 2);
        busy_run = 0;
      end
      prev_fr = Frame_ready;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_data  = b;
    rx_valid = 1;
    @(posedge clock);
    #1 rx_valid = 0;
  endtask

  // Checksum is the plain XOR of the ten bytes between sync and checksum.
  task automatic send_frame(input logic [3:0] hi, input logic [11:0] id, input logic [63:0] d,
                            input bit bad, input int nbytes = 12);
    logic [7:0] b[12];
    logic [7:0] cs;
    b[0] = 8'hA5;
    b[1] = {hi, id[11:8]};
    b[2] = id[7:0];
    for (int i = 0; i < 8; i++) b[3+i] = d[8*i +: 8];
    cs = 0;
    for (int i = 1; i <= 10; i++) cs ^= b[i];
    b[11] = bad ? cs ^ 8'($urandom_range(1, 255)) : cs;
    for (int i = 0; i < nbytes; i++) send_byte(b[i]);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_id"}, Can_ID_Bus, 0);
    chk({tag, "_data"}, can_tx_data_bus, 0);
    chk({tag, "_flags"}, {Frame_ready, Load_frame_datareg, T_frame, busy, frame_err, overrun}, 0);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clock);
    reset = 1;
    repeat (2) @(negedge clock);
    check_quiet(tag);
    reset = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600 && (busy || exp_q.size() != 0); i++) @(negedge clock);
    @(negedge clock);
  endtask

  task automatic rand_frame(output logic [3:0] hi, output logic [11:0] id, output logic [63:0] d);
    hi = 4'($urandom);
    id = 12'($urandom);
    d  = {$urandom, $urandom};
  endtask

  initial begin
    logic [3:0]  hi;
    logic [11:0] id, id2, id3;
    logic [63:0] d, d2, d3;
    int f0, e0, o0, t0;
    repeat (3) @(negedge clock);
    check_quiet("reset");
    reset = 0;

    // Reference frame: latency, launch contents, strobe alignment
    exp_q.push_back({12'h123, 64'h8877665544332211});
    send_frame(4'h0, 12'h123, 64'h8877665544332211, 0);
    @(negedge clock);
    chk("ref_frame_ready", Frame_ready, 1);
    chk("ref_busy", busy, 1);
    @(negedge clock);
    chk("ref_t_frame", T_frame, 1);
    chk("ref_ready_dropped", Frame_ready, 0);
    wait_idle();
    chk("ref_id_held", Can_ID_Bus, 12'h123);
    chk("ref_data_held", can_tx_data_bus, 64'h8877665544332211);

    // Bad checksum
    f0 = fr_cnt;
    e0 = err_cnt;
    send_frame(4'h0, 12'h123, 64'h8877665544332211, 1);
    @(negedge clock);
    chk("bad_csum_err", frame_err, 1);
    chk("bad_csum_no_ready", Frame_ready, 0);
    repeat (3) @(negedge clock);
    chk("bad_csum_err_count", err_cnt - e0, 1);
    chk("bad_csum_no_launch", fr_cnt - f0, 0);

    // Noise before sync, then a random frame
    e0 = err_cnt;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    repeat (2) @(negedge clock);
    chk("noise_no_pulse", {Frame_ready, frame_err, overrun, busy}, 0);
    rand_frame(hi, id, d);
    exp_q.push_back({id, d});
    send_frame(hi, id, d, 0);
    wait_idle();
    chk("noise_then_frame", fr_cnt - f0, 1);
    chk("noise_no_err", err_cnt - e0, 0);

    // Inter-byte timeout boundary
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (10000) @(negedge clock);
    chk("timeout_not_yet", frame_err, 0);
    @(negedge clock);
    chk("timeout_err", frame_err, 1);
    rand_frame(hi, id, d);
    exp_q.push_back({id, d});
    f0 = fr_cnt;
    send_frame(hi, id, d, 0);
    wait_idle();
    chk("after_timeout_launch", fr_cnt - f0, 1);

    // Three back-to-back frames: second waits out the guard, third overruns
    f0 = fr_cnt;
    o0 = ovr_cnt;
    rand_frame(hi, id, d);
    rand_frame(hi, id2, d2);
    rand_frame(hi, id3, d3);
    exp_q.push_back({id, d});
    exp_q.push_back({id2, d2});
    send_frame(hi, id, d, 0);
    send_frame(4'($urandom), id2, d2, 0);
    send_frame(4'($urandom), id3, d3, 0);
    wait_idle();
    chk("b2b_launches", fr_cnt - f0, 2);
    chk("b2b_overrun", ovr_cnt - o0, 1);

    // Third frame completes on the exact cycle the pending one loads: set wins
    f0 = fr_cnt;
    o0 = ovr_cnt;
    rand_frame(hi, id, d);
    rand_frame(hi, id2, d2);
    rand_frame(hi, id3, d3);
    exp_q.push_back({id, d});
    exp_q.push_back({id2, d2});
    exp_q.push_back({id3, d3});
    send_frame(hi, id, d, 0);
    send_frame(hi, id2, d2, 0);
    repeat (GUARD - 21) @(posedge clock);
    send_frame(hi, id3, d3, 0);
    chk("set_wins_ready", Frame_ready, 1);
    wait_idle();
    chk("set_wins_launches", fr_cnt - f0, 3);
    chk("set_wins_no_overrun", ovr_cnt - o0, 0);

    // Reset mid-DATA and mid-GUARD
    f0 = fr_cnt;
    t0 = tf_cnt;
    rand_frame(hi, id, d);
    send_frame(hi, id, d, 0, 6);
    pulse_reset("rst_data");
    repeat (30) @(negedge clock);
    chk("rst_data_no_launch", fr_cnt - f0, 0);
    rand_frame(hi, id, d);
    exp_q.push_back({id, d});
    send_frame(hi, id, d, 0);
    repeat (20) @(negedge clock);
    chk("rst_guard_busy", busy, 1);
    pulse_reset("rst_guard");
    repeat (GUARD + 20) @(negedge clock);
    chk("rst_guard_one_launch", fr_cnt - f0, 1);
    chk("rst_guard_one_fire", tf_cnt - t0, 1);
    chk("rst_guard_quiet", {Frame_ready, T_frame, busy, Can_ID_Bus}, 0);
    rand_frame(hi, id, d);
    exp_q.push_back({id, d});
    send_frame(hi, id, d, 0);
    wait_idle();
    chk("rst_then_launch", fr_cnt - f0, 2);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
